// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: victim query, optional dirty write-back, line refill, fill/LRU update.
// Write-back support is compiled in only when DCACHE_WRITEBACK_EN is defined.
module dcache_miss_ctrl #(
    parameter int DCACHE_NUM_SET  = 4,
    parameter int DCACHE_NUM_WAYS = 4,
    parameter int ADDR_W          = 32,
    parameter int LINE_W          = 128,
    localparam int SET_W          = $clog2(DCACHE_NUM_SET),
    localparam int WAY_W          = $clog2(DCACHE_NUM_WAYS),
    localparam int OFF_W          = $clog2(LINE_W / 8)
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       miss_req,
    input  logic [ADDR_W-1:0]          miss_addr,
    output logic                       miss_ready,
    output logic                       victim_req,
    output logic [SET_W-1:0]           victim_set,
    input  logic [WAY_W-1:0]           victim_way,
    input  logic [DCACHE_NUM_WAYS-1:0] way_dirty,
    input  logic [ADDR_W-1:0]          victim_line_addr,
    input  logic [LINE_W-1:0]          victim_line_data,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [LINE_W-1:0]          mem_wdata,
    input  logic                       mem_ack,
    input  logic [LINE_W-1:0]          mem_rdata,
    output logic                       fill_valid,
    output logic [SET_W-1:0]           fill_set,
    output logic [WAY_W-1:0]           fill_way,
    output logic [ADDR_W-1:0]          fill_addr,
    output logic [LINE_W-1:0]          fill_data,
    output logic                       update_req,
    output logic [SET_W-1:0]           update_set,
    output logic [WAY_W-1:0]           update_way
);

    typedef enum logic [2:0] {
        IDLE,
        VICTIM,
`ifdef DCACHE_WRITEBACK_EN
        WRITEBACK,
`endif
        READ,
        FILL
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] line_q;
    logic [WAY_W-1:0]  way_q;

    // Byte-offset bits never matter: the controller works on whole lines.
`ifdef DCACHE_WRITEBACK_EN
    logic unused_bits;
    assign unused_bits = ^miss_addr[OFF_W-1:0];
`else
    logic unused_bits;
    assign unused_bits = ^{miss_addr[OFF_W-1:0], way_dirty, victim_line_addr, victim_line_data};
    assign mem_we      = 1'b0;
    assign mem_wdata   = '0;
`endif

    // NOTE: every register here uses <= so all updates see the pre-edge values of their peers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            miss_ready <= 1'b1;
            line_q     <= '0;
            way_q      <= '0;
            victim_req <= 1'b0;
            victim_set <= '0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
`ifdef DCACHE_WRITEBACK_EN
            mem_we     <= 1'b0;
            mem_wdata  <= '0;
`endif
            fill_valid <= 1'b0;
            fill_set   <= '0;
            fill_way   <= '0;
            fill_addr  <= '0;
            fill_data  <= '0;
            update_req <= 1'b0;
            update_set <= '0;
            update_way <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_req) begin
                        line_q     <= {miss_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        miss_ready <= 1'b0;
                        victim_req <= 1'b1;
                        victim_set <= miss_addr[OFF_W +: SET_W];
                        state      <= VICTIM;
                    end
                end
                VICTIM: begin
                    victim_req <= 1'b0;
                    victim_set <= '0;
                    way_q      <= victim_way;
                    mem_req    <= 1'b1;
`ifdef DCACHE_WRITEBACK_EN
                    if (way_dirty[victim_way]) begin
                        mem_we    <= 1'b1;
                        mem_addr  <= victim_line_addr;
                        mem_wdata <= victim_line_data;
                        state     <= WRITEBACK;
                    end else begin
                        mem_addr <= line_q;
                        state    <= READ;
                    end
`else
                    mem_addr <= line_q;
                    state    <= READ;
`endif
                end
`ifdef DCACHE_WRITEBACK_EN
                WRITEBACK: begin
                    if (mem_ack) begin
                        mem_we    <= 1'b0;
                        mem_wdata <= '0;
                        mem_addr  <= line_q;
                        state     <= READ;
                    end
                end
`endif
                READ: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        mem_addr   <= '0;
                        fill_valid <= 1'b1;
                        fill_set   <= line_q[OFF_W +: SET_W];
                        fill_way   <= way_q;
                        fill_addr  <= line_q;
                        fill_data  <= mem_rdata;
                        update_req <= 1'b1;
                        update_set <= line_q[OFF_W +: SET_W];
                        update_way <= way_q;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    fill_valid <= 1'b0;
                    fill_set   <= '0;
                    fill_way   <= '0;
                    fill_addr  <= '0;
                    fill_data  <= '0;
                    update_req <= 1'b0;
                    update_set <= '0;
                    update_way <= '0;
                    miss_ready <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    miss_ready <= 1'b1;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Directed bench for dcache_miss_ctrl; covers both builds of DCACHE_WRITEBACK_EN.
module tb_dcache_miss_ctrl;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 128;
    localparam int SET_W  = 2;
    localparam int WAY_W  = 2;
    localparam int NWAYS  = 4;

    localparam logic [LINE_W-1:0] D1 = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    localparam logic [LINE_W-1:0] D2 = 128'hdead_beef_0000_1111_2222_3333_4444_5555;
    localparam logic [LINE_W-1:0] D3 = 128'ha5a5_5a5a_c3c3_3c3c_0f0f_f0f0_1234_8765;
    localparam logic [LINE_W-1:0] D4 = 128'h7777_8888_9999_aaaa_bbbb_cccc_dddd_eeee;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              miss_req;
    logic [ADDR_W-1:0] miss_addr;
    logic              miss_ready;
    logic              victim_req;
    logic [SET_W-1:0]  victim_set;
    logic [WAY_W-1:0]  victim_way;
    logic [NWAYS-1:0]  way_dirty;
    logic [ADDR_W-1:0] victim_line_addr;
    logic [LINE_W-1:0] victim_line_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_rdata;
    logic              fill_valid;
    logic [SET_W-1:0]  fill_set;
    logic [WAY_W-1:0]  fill_way;
    logic [ADDR_W-1:0] fill_addr;
    logic [LINE_W-1:0] fill_data;
    logic              update_req;
    logic [SET_W-1:0]  update_set;
    logic [WAY_W-1:0]  update_way;

    int total = 0;
    int bad   = 0;
    int fill_count = 0;
    bit we_seen = 1'b0;
    int we_cycles;
    int lat;

    dcache_miss_ctrl dut (
        .clock            (clock),
        .reset            (reset),
        .miss_req         (miss_req),
        .miss_addr        (miss_addr),
        .miss_ready       (miss_ready),
        .victim_req       (victim_req),
        .victim_set       (victim_set),
        .victim_way       (victim_way),
        .way_dirty        (way_dirty),
        .victim_line_addr (victim_line_addr),
        .victim_line_data (victim_line_data),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .fill_valid       (fill_valid),
        .fill_set         (fill_set),
        .fill_way         (fill_way),
        .fill_addr        (fill_addr),
        .fill_data        (fill_data),
        .update_req       (update_req),
        .update_set       (update_set),
        .update_way       (update_way)
    );

    always #5 clock = ~clock;

    // Fill pulses and write strobes seen across the whole run.
    always @(negedge clock) begin
        if (mem_we)     we_seen    <= 1'b1;
        if (fill_valid) fill_count <= fill_count + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        miss_req         = 1'b0;
        miss_addr        = '0;
        victim_way       = '0;
        way_dirty        = '0;
        victim_line_addr = '0;
        victim_line_data = '0;
        mem_ack          = 1'b0;
        mem_rdata        = '0;

        // Reset state
        tick();
        tick();
        check("rst_miss_ready", 128'(miss_ready), 128'(1));
        check("rst_victim_req", 128'(victim_req), 128'(0));
        check("rst_mem_req",    128'(mem_req),    128'(0));
        check("rst_fill_valid", 128'(fill_valid), 128'(0));
        check("rst_update_req", 128'(update_req), 128'(0));
        check("rst_mem_addr",   128'(mem_addr),   128'(0));
        reset = 1'b0;
        tick();
        check("idle_ready", 128'(miss_ready), 128'(1));

        // Clean miss to 0x40 (offset bits set on input), victim way 2, immediate ack
        miss_req   = 1'b1;
        miss_addr  = 32'h0000_0047;
        victim_way = 2'd2;
        way_dirty  = 4'b1011;
        tick();
        miss_req = 1'b0;
        check("c_victim_req", 128'(victim_req), 128'(1));
        check("c_victim_set", 128'(victim_set), 128'(0));
        check("c_ready_busy", 128'(miss_ready), 128'(0));
        check("c_memreq_vic", 128'(mem_req),    128'(0));
        tick();
        check("c_rd_req",      128'(mem_req),    128'(1));
        check("c_rd_we",       128'(mem_we),     128'(0));
        check("c_rd_addr",     128'(mem_addr),   128'(32'h40));
        check("c_vic_req_off", 128'(victim_req), 128'(0));
        check("c_vic_set_off", 128'(victim_set), 128'(0));
        mem_ack   = 1'b1;
        mem_rdata = D1;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        check("c_fill_valid", 128'(fill_valid), 128'(1));
        check("c_update_req", 128'(update_req), 128'(1));
        check("c_fill_set",   128'(fill_set),   128'(0));
        check("c_fill_way",   128'(fill_way),   128'(2));
        check("c_upd_set",    128'(update_set), 128'(0));
        check("c_upd_way",    128'(update_way), 128'(2));
        check("c_fill_addr",  128'(fill_addr),  128'(32'h40));
        check("c_fill_data",  fill_data,        D1);
        check("c_memreq_off", 128'(mem_req),    128'(0));
        check("c_memaddr_0",  128'(mem_addr),   128'(0));
        tick();
        check("c_fill_end",   128'(fill_valid), 128'(0));
        check("c_upd_end",    128'(update_req), 128'(0));
        check("c_fdata_0",    fill_data,        128'(0));
        check("c_ready_back", 128'(miss_ready), 128'(1));

        // Stray ack while idle
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        check("ia_ready",  128'(miss_ready), 128'(1));
        check("ia_memreq", 128'(mem_req),    128'(0));
        check("ia_fill",   128'(fill_valid), 128'(0));
        check("ia_vic",    128'(victim_req), 128'(0));

        // Dirty victim, miss_req held high for the whole transaction
        miss_addr        = 32'h0000_2358;
        miss_req         = 1'b1;
        victim_way       = 2'd1;
        way_dirty        = 4'hF;
        victim_line_addr = 32'h0000_1230;
        victim_line_data = D2;
        tick();
        check("d_victim_req", 128'(victim_req), 128'(1));
        check("d_victim_set", 128'(victim_set), 128'(1));
        tick();
`ifdef DCACHE_WRITEBACK_EN
        we_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) mem_ack = 1'b1;
            check("wb_we",    128'(mem_we),   128'(1));
            check("wb_req",   128'(mem_req),  128'(1));
            check("wb_addr",  128'(mem_addr), 128'(32'h1230));
            check("wb_wdata", mem_wdata,      D2);
            if (mem_we) we_cycles++;
            tick();
        end
        mem_ack = 1'b0;
        check("wb_cycles", 128'(we_cycles), 128'(6));
`endif
        check("d_rd_we",    128'(mem_we),   128'(0));
        check("d_rd_req",   128'(mem_req),  128'(1));
        check("d_rd_addr",  128'(mem_addr), 128'(32'h2350));
        check("d_rd_wdata", mem_wdata,      128'(0));
        tick();
        tick();
        check("d_wait_req",   128'(mem_req),    128'(1));
        check("d_wait_fill",  128'(fill_valid), 128'(0));
        check("d_wait_ready", 128'(miss_ready), 128'(0));
        mem_ack   = 1'b1;
        mem_rdata = D3;
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        check("d_fill_valid", 128'(fill_valid), 128'(1));
        check("d_fill_set",   128'(fill_set),   128'(1));
        check("d_fill_way",   128'(fill_way),   128'(1));
        check("d_upd_set",    128'(update_set), 128'(1));
        check("d_upd_way",    128'(update_way), 128'(1));
        check("d_fill_addr",  128'(fill_addr),  128'(32'h2350));
        check("d_fill_data",  fill_data,        D3);
        tick();
        check("h_ready_after_fill", 128'(miss_ready), 128'(1));
        check("h_fill_count",       128'(fill_count), 128'(2));

        // Held miss_req is taken on the edge right after the FILL cycle
        way_dirty  = '0;
        victim_way = 2'd3;
        tick();
        miss_req = 1'b0;
        check("h_victim_req", 128'(victim_req), 128'(1));
        check("h_victim_set", 128'(victim_set), 128'(1));
        tick();
        check("h_rd_req", 128'(mem_req), 128'(1));

        // Reset in the middle of READ, before any ack
        #2 reset = 1'b1;
        #1;
        check("r_memreq",  128'(mem_req),    128'(0));
        check("r_memaddr", 128'(mem_addr),   128'(0));
        check("r_fill",    128'(fill_valid), 128'(0));
        check("r_upd",     128'(update_req), 128'(0));
        check("r_vic",     128'(victim_req), 128'(0));
        check("r_ready",   128'(miss_ready), 128'(1));
        mem_ack = 1'b1;
        tick();
        tick();
        mem_ack = 1'b0;
        reset   = 1'b0;
        tick();
        tick();
        check("r_post_fill",  128'(fill_valid), 128'(0));
        check("r_post_upd",   128'(update_req), 128'(0));
        check("r_post_ready", 128'(miss_ready), 128'(1));
        check("r_post_memrq", 128'(mem_req),    128'(0));
        check("r_fill_count", 128'(fill_count), 128'(2));

        // Minimum latency: ack already high, clean victim, set 3 way 0
        miss_addr  = 32'h0000_0F30;
        miss_req   = 1'b1;
        victim_way = 2'd0;
        mem_ack    = 1'b1;
        mem_rdata  = D4;
        tick();
        miss_req = 1'b0;
        lat = 1;
        while (!fill_valid && lat < 10) begin
            tick();
            lat++;
        end
        check("l_latency",   128'(lat),        128'(3));
        check("l_fill_set",  128'(fill_set),   128'(3));
        check("l_fill_way",  128'(fill_way),   128'(0));
        check("l_fill_addr", 128'(fill_addr),  128'(32'hF30));
        check("l_fill_data", fill_data,        D4);
        mem_ack = 1'b0;
        tick();
        check("l_ready",      128'(miss_ready), 128'(1));
        check("l_fill_count", 128'(fill_count), 128'(3));

`ifndef DCACHE_WRITEBACK_EN
        check("nowb_we_never", 128'(we_seen), 128'(0));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dcache_miss_ctrl.md
DCACHE_MISS_CTRL -- requirements
Module: dcache_miss_ctrl

Interface
REQ-001 SHALL have parameter DCACHE_NUM_SET, default 4, number of sets; SET_W = log2(DCACHE_NUM_SET).
REQ-002 SHALL have parameter DCACHE_NUM_WAYS, default 4, ways per set; WAY_W = log2(DCACHE_NUM_WAYS).
REQ-003 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-004 SHALL have parameter LINE_W, default 128, line width in bits; OFF_W = log2(LINE_W/8).
REQ-005 SHALL have port clock, input, 1, single clock; all state updates on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-007 SHALL have ports miss_req (in, 1), miss_addr (in, ADDR_W) and miss_ready (out, 1), forming the miss handshake from the pipeline.
REQ-008 SHALL have ports victim_req (out, 1), victim_set (out, SET_W) and victim_way (in, WAY_W), forming the LRU victim query; victim_way is combinational, valid in the same cycle.
REQ-009 SHALL have ports way_dirty (in, DCACHE_NUM_WAYS), victim_line_addr (in, ADDR_W) and victim_line_data (in, LINE_W), carrying tag-array contents for victim_set/victim_way, valid in the same cycle.
REQ-010 SHALL have ports mem_req (out, 1), mem_we (out, 1), mem_addr (out, ADDR_W), mem_wdata (out, LINE_W), mem_ack (in, 1) and mem_rdata (in, LINE_W), forming the line memory interface.
REQ-011 SHALL have ports fill_valid (out, 1), fill_set (out, SET_W), fill_way (out, WAY_W), fill_addr (out, ADDR_W) and fill_data (out, LINE_W), forming the cache array write.
REQ-012 SHALL have ports update_req (out, 1), update_set (out, SET_W) and update_way (out, WAY_W), forming the LRU update.

Function
REQ-013 SHALL implement FSM states IDLE, VICTIM, WRITEBACK, READ, FILL.
REQ-014 SHALL drive miss_ready = 1 only in IDLE.
REQ-015 SHALL, in IDLE, when miss_req & miss_ready, latch miss_addr with the low OFF_W bits zeroed, set index = miss_addr[OFF_W +: SET_W], and go to VICTIM.
REQ-016 SHALL, in VICTIM (exactly 1 cycle), drive victim_req = 1 and victim_set = latched set, and capture victim_way, way_dirty[victim_way], victim_line_addr and victim_line_data.
REQ-017 SHALL transition from VICTIM to WRITEBACK if the captured dirty bit = 1, else to READ.
REQ-018 SHALL, in WRITEBACK, hold mem_req = 1, mem_we = 1, mem_addr = captured victim_line_addr and mem_wdata = captured data stable until mem_ack, then go to READ.
REQ-019 SHALL, in READ, hold mem_req = 1, mem_we = 0 and mem_addr = latched miss line address until mem_ack, capture mem_rdata on the ack cycle, and go to FILL.
REQ-020 SHALL treat mem_ack as accepted only while mem_req = 1; an ack in the same cycle that mem_req first asserts completes the transfer; acks at other times SHALL be ignored.
REQ-021 SHALL, in FILL (exactly 1 cycle), assert fill_valid and update_req together with fill_set = update_set = latched set, fill_way = update_way = captured way, fill_addr = miss line address and fill_data = captured rdata, then go to IDLE.
REQ-022 SHALL keep victim_req, mem_req, fill_valid and update_req at 0 outside their states; data/address outputs SHALL be 0 whenever their strobe is 0.
REQ-023 SHALL make minimum miss latency (accept to FILL) equal to 3 cycles with clean victim and immediate ack; the next miss SHALL be accepted in the cycle after FILL.
REQ-024 SHALL ignore miss_req while not in IDLE; the miss is not queued.

Reset
REQ-025 SHALL, on reset assertion at any time (including mid-transfer), go to IDLE immediately and abandon any memory transaction without a fill or LRU update.
REQ-026 SHALL hold all outputs at 0 during reset except miss_ready, which SHALL be 1 once in IDLE; all latched registers SHALL clear to 0.

Configuration
REQ-027 SHALL compile write-back support in when macro DCACHE_WRITEBACK_EN is defined: dirty victims follow REQ-017/REQ-018.
REQ-028 SHALL, with DCACHE_WRITEBACK_EN undefined, omit the WRITEBACK state, ignore way_dirty, always go VICTIM->READ, and tie mem_we and mem_wdata to 0.

Verification
REQ-029 SHALL cover: clean miss addr 0x0000_0040, set 0, victim_way 2, mem_ack in first READ cycle -> FILL 3 cycles after accept, set=0, way=2, update_req and fill_valid high in one cycle.
REQ-030 SHALL cover: dirty victim, victim_line_addr 0x0000_1230, ack delayed 5 cycles -> WRITEBACK mem_we=1, addr 0x0000_1230 held 6 cycles, then READ addr = miss line.
REQ-031 SHALL cover: miss_req held high during busy -> single fill only; second miss accepted the cycle after FILL.
REQ-032 SHALL cover: reset asserted in READ before ack -> outputs 0 the same cycle, no fill_valid/update_req, miss_ready = 1 after release.
REQ-033 SHALL cover: mem_ack pulsed while in IDLE -> no state change; with DCACHE_WRITEBACK_EN undefined and way_dirty all 1s -> mem_we never asserts.
